cp0_regfile: RTL and testbench

CP0 register file and exception-commit logic for the 5-stage MIPS core, located in the WB stage.
- Commits exceptions, interrupts and ERET for the instruction in WB.
- Updates Status, Cause, EPC and BadVAddr, runs the Count/Compare timer, and services MTC0/MFC0.
- Drives is_exl, cause_type and cp0_epc to the downstream exception-address/redirect logic, which turns them into a PC redirect and a pipeline flush.

---
 rtl/cp0_pkg.sv | 47 ++++
 rtl/cp0_timer.sv | 66 ++++++
 rtl/cp0_regfile.sv | 163 ++++++++++++++++
 tb/tb_cp0_regfile.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 register file.
//   - CP0 register addresses as {rd[4:0], sel[2:0]}
//   - ExcCode values plus the cause_type markers for ERET and idle
//   - Status / Cause bit positions and the Status write mask
//   - commit-action enum used by the WB-stage commit logic
package cp0_pkg;

   localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
   localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
   localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
   localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
   localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
   localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

   localparam logic [4:0] EXC_INT    = 5'h00;
   localparam logic [4:0] EXC_ADEL   = 5'h04;
   localparam logic [4:0] EXC_ADES   = 5'h05;
   localparam logic [4:0] EXC_SYS    = 5'h08;
   localparam logic [4:0] EXC_BP     = 5'h09;
   localparam logic [4:0] EXC_RI     = 5'h0A;
   localparam logic [4:0] EXC_OV     = 5'h0C;
   localparam logic [4:0] CAUSE_ERET = 5'h10;
   localparam logic [4:0] CAUSE_NONE = 5'h1F;

   localparam int ST_IE     = 0;
   localparam int ST_EXL    = 1;
   localparam int ST_IM_LSB = 8;
   localparam int ST_IM_MSB = 15;
   localparam int CA_SW_LSB = 8;
   localparam int CA_SW_MSB = 9;

   // IM[15:8], EXL, IE are the only software-writable Status bits
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

   typedef enum logic [1:0] {
      ACT_NONE,
      ACT_EXC,
      ACT_ERET,
      ACT_MTC0
   } cp0_act_e;

   // codes that also capture the faulting address into BadVAddr
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer.
//   clk_i, rst_i      : clock, async active-high reset
//   count_we_i        : load Count from wdata_i
//   compare_we_i      : load Compare from wdata_i, clears TI
//   wdata_i           : MTC0 data
//   count_o/compare_o : register values for MFC0
//   ti_o              : timer interrupt pending
module cp0_timer #(
   parameter int COUNT_W = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               count_we_i,
   input  logic               compare_we_i,
   input  logic [COUNT_W-1:0] wdata_i,
   output logic [COUNT_W-1:0] count_o,
   output logic [COUNT_W-1:0] compare_o,
   output logic               ti_o
);

   logic               tick_q, tick_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [COUNT_W-1:0] compare_q, compare_d;
   logic               ti_q, ti_d;
   logic [COUNT_W-1:0] count_inc;

   assign count_inc = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      // tick free-runs; a Count load does not re-phase it
      tick_d    = ~tick_q;
      count_d   = count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      if (count_we_i)
         count_d = wdata_i;
      else if (tick_q)
         count_d = count_inc;
      if (compare_we_i)
         compare_d = wdata_i;
      // a Compare write always clears TI, even if Count hits the old Compare on the same edge
      if (compare_we_i)
         ti_d = 1'b0;
      else if (tick_q && !count_we_i && (count_inc == compare_q))
         ti_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tick_q    <= 1'b0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         tick_q    <= tick_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 registers and WB-stage exception/interrupt/ERET commit.
//   clk, reset             : clock, async active-high reset
//   wb_*                   : instruction in WB (valid, pc, delay slot, exception,
//                            ERET, MTC0 address/data, faulting address)
//   hw_int                 : level-sensitive external interrupt lines
//   cp0_rdata              : MFC0 data, combinational on wb_cp0_addr
//   is_exl / cause_type    : commit indication for the redirect logic
//   cp0_epc / status_exl   : current EPC and Status.EXL
module cp0_regfile
   import cp0_pkg::*;
#(
   parameter logic [31:0] STATUS_RST = 32'h0040_0000,
   parameter int          COUNT_W    = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid,
   input  logic [31:0] wb_pc,
   input  logic        wb_bd,
   input  logic        wb_exc_valid,
   input  logic [4:0]  wb_exc_code,
   input  logic [31:0] wb_badvaddr,
   input  logic        wb_eret,
   input  logic        wb_mtc0,
   input  logic [7:0]  wb_cp0_addr,
   input  logic [31:0] wb_cp0_wdata,
   output logic [31:0] cp0_rdata,
   input  logic [5:0]  hw_int,
   output logic        is_exl,
   output logic [4:0]  cause_type,
   output logic [31:0] cp0_epc,
   output logic        status_exl
);

   logic [31:0]        status_q, status_d;
   logic [31:0]        epc_q, epc_d;
   logic [31:0]        badvaddr_q, badvaddr_d;
   logic               cause_bd_q, cause_bd_d;
   logic [4:0]         cause_exc_q, cause_exc_d;
   logic [5:0]         ip_hw_q, ip_hw_d;
   logic [1:0]         ip_sw_q, ip_sw_d;

   logic [COUNT_W-1:0] count, compare;
   logic               ti;
   logic               wb_act, int_req, mtc0_we;
   logic [7:0]         cause_ip;
   logic [31:0]        cause_rd;
   cp0_act_e           act;
   logic [4:0]         commit_code;

   // holding reset forces the idle outputs even if WB inputs are live
   assign wb_act   = wb_valid & ~reset;
   assign cause_ip = {ip_hw_q, ip_sw_q};
   assign int_req  = (|(cause_ip & status_q[ST_IM_MSB:ST_IM_LSB]))
                   & status_q[ST_IE] & ~status_q[ST_EXL];

   // one action per instruction: interrupt > exception > ERET > MTC0
   always_comb begin
      act         = ACT_NONE;
      commit_code = CAUSE_NONE;
      if (wb_act) begin
         if (int_req) begin
            act         = ACT_EXC;
            commit_code = EXC_INT;
         end else if (wb_exc_valid) begin
            act         = ACT_EXC;
            commit_code = wb_exc_code;
         end else if (wb_eret) begin
            act         = ACT_ERET;
            commit_code = CAUSE_ERET;
         end else if (wb_mtc0) begin
            act         = ACT_MTC0;
         end
      end
   end

   assign is_exl     = (act == ACT_EXC);
   assign cause_type = commit_code;
   assign mtc0_we    = (act == ACT_MTC0);

   cp0_timer #(.COUNT_W(COUNT_W)) u_timer (
      .clk_i        (clk),
      .rst_i        (reset),
      .count_we_i   (mtc0_we && (wb_cp0_addr == CP0_COUNT)),
      .compare_we_i (mtc0_we && (wb_cp0_addr == CP0_COMPARE)),
      .wdata_i      (wb_cp0_wdata[COUNT_W-1:0]),
      .count_o      (count),
      .compare_o    (compare),
      .ti_o         (ti)
   );

   always_comb begin
      status_d    = status_q;
      epc_d       = epc_q;
      badvaddr_d  = badvaddr_q;
      cause_bd_d  = cause_bd_q;
      cause_exc_d = cause_exc_q;
      ip_sw_d     = ip_sw_q;
      // timer interrupt shares line 5 with hw_int[5]
      ip_hw_d     = {hw_int[5] | ti, hw_int[4:0]};
      case (act)
         ACT_EXC: begin
            cause_exc_d = commit_code;
            // nested exception keeps the original return point
            if (!status_q[ST_EXL]) begin
               epc_d      = wb_bd ? (wb_pc - 32'd4) : wb_pc;
               cause_bd_d = wb_bd;
            end
            status_d[ST_EXL] = 1'b1;
            if (is_addr_exc(commit_code))
               badvaddr_d = wb_badvaddr;
         end
         ACT_ERET: status_d[ST_EXL] = 1'b0;
         ACT_MTC0: begin
            case (wb_cp0_addr)
               CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wb_cp0_wdata & STATUS_WMASK);
               CP0_CAUSE:  ip_sw_d  = wb_cp0_wdata[CA_SW_MSB:CA_SW_LSB];
               CP0_EPC:    epc_d    = wb_cp0_wdata;
               default:    ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         status_q    <= STATUS_RST;
         epc_q       <= '0;
         badvaddr_q  <= '0;
         cause_bd_q  <= 1'b0;
         cause_exc_q <= '0;
         ip_hw_q     <= '0;
         ip_sw_q     <= '0;
      end else begin
         status_q    <= status_d;
         epc_q       <= epc_d;
         badvaddr_q  <= badvaddr_d;
         cause_bd_q  <= cause_bd_d;
         cause_exc_q <= cause_exc_d;
         ip_hw_q     <= ip_hw_d;
         ip_sw_q     <= ip_sw_d;
      end
   end

   assign cause_rd = {cause_bd_q, ti, 14'b0, cause_ip, 1'b0, cause_exc_q, 2'b00};

   always_comb begin
      case (wb_cp0_addr)
         CP0_BADVADDR: cp0_rdata = badvaddr_q;
         CP0_COUNT:    cp0_rdata = 32'(count);
         CP0_COMPARE:  cp0_rdata = 32'(compare);
         CP0_STATUS:   cp0_rdata = status_q;
         CP0_CAUSE:    cp0_rdata = cause_rd;
         CP0_EPC:      cp0_rdata = epc_q;
         default:      cp0_rdata = 32'h0;
      endcase
   end

   assign cp0_epc    = epc_q;
   assign status_exl = status_q[ST_EXL];

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;
   import cp0_pkg::*;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic        bd;
      logic        exc;
      logic [4:0]  code;
      logic [31:0] badv;
      logic        eret;
      logic        mtc0;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [5:0]  hw;
   } vin_t;

   typedef struct {
      vin_t        v;
      logic        isexl;
      logic [4:0]  ct;
      logic [31:0] epc;
      logic        sexl;
      logic [31:0] rdata;
   } row_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   vin_t        cur;
   logic [31:0] cp0_rdata, cp0_epc;
   logic        is_exl, status_exl;
   logic [4:0]  cause_type;
   int          checks = 0;
   int          failures = 0;
   row_t        rows[$];
   logic [7:0]  alist[8] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h78, 8'h49};
   logic [4:0]  clist[6];

   always #5 clk = ~clk;

   cp0_regfile dut (
      .clk(clk), .reset(rst), .wb_valid(cur.valid), .wb_pc(cur.pc), .wb_bd(cur.bd),
      .wb_exc_valid(cur.exc), .wb_exc_code(cur.code), .wb_badvaddr(cur.badv),
      .wb_eret(cur.eret), .wb_mtc0(cur.mtc0), .wb_cp0_addr(cur.addr),
      .wb_cp0_wdata(cur.wdata), .cp0_rdata(cp0_rdata), .hw_int(cur.hw),
      .is_exl(is_exl), .cause_type(cause_type), .cp0_epc(cp0_epc), .status_exl(status_exl)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string t, input logic x, input logic [4:0] ct,
                           input logic [31:0] epc, input logic sx, input logic [31:0] rd);
      chk({t, ".is_exl"}, 32'(is_exl), 32'(x));
      chk({t, ".cause_type"}, 32'(cause_type), 32'(ct));
      chk({t, ".cp0_epc"}, cp0_epc, epc);
      chk({t, ".status_exl"}, 32'(status_exl), 32'(sx));
      chk({t, ".rdata"}, cp0_rdata, rd);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus builders ----------------
   function automatic vin_t rd(input logic [7:0] a);
      vin_t v;
      v.valid = 0; v.pc = 0; v.bd = 0; v.exc = 0; v.code = 0; v.badv = 0;
      v.eret = 0; v.mtc0 = 0; v.addr = a; v.wdata = 0; v.hw = 0;
      return v;
   endfunction

   function automatic vin_t ex(input logic [4:0] c, input logic [31:0] pc, input logic bd,
                               input logic [31:0] badv, input logic [7:0] a);
      vin_t v = rd(a);
      v.valid = 1; v.exc = 1; v.code = c; v.pc = pc; v.bd = bd; v.badv = badv;
      return v;
   endfunction

   function automatic vin_t er(input logic [7:0] a);
      vin_t v = rd(a);
      v.valid = 1; v.eret = 1;
      return v;
   endfunction

   function automatic vin_t mt(input logic [7:0] a, input logic [31:0] d);
      vin_t v = rd(a);
      v.valid = 1; v.mtc0 = 1; v.wdata = d;
      return v;
   endfunction

   task automatic add(input vin_t v, input logic x, input logic [4:0] ct,
                      input logic [31:0] epc, input logic sx, input logic [31:0] rdv);
      row_t r;
      r.v = v; r.isexl = x; r.ct = ct; r.epc = epc; r.sexl = sx; r.rdata = rdv;
      rows.push_back(r);
   endtask

   // ---------------- reference model ----------------
   // Timer phase is derived from the number of edges since reset: Count
   // advances on every second edge, starting with the second one.
   logic [31:0] m_status, m_epc, m_badv, m_count, m_compare;
   logic        m_bd, m_ti;
   logic [4:0]  m_excode;
   logic [5:0]  m_iphw;
   logic [1:0]  m_ipsw;
   int          m_edges;

   task automatic m_reset();
      m_status = 32'h0040_0000; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
      m_bd = 0; m_ti = 0; m_excode = 0; m_iphw = 0; m_ipsw = 0; m_edges = 0;
   endtask

   function automatic logic m_irq();
      logic [7:0] pend = {m_iphw, m_ipsw} & m_status[15:8];
      return (pend != 0) && m_status[0] && !m_status[1];
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      case (a)
         CP0_BADVADDR: return m_badv;
         CP0_COUNT:    return m_count;
         CP0_COMPARE:  return m_compare;
         CP0_STATUS:   return m_status;
         CP0_CAUSE:    return {m_bd, m_ti, 14'b0, m_iphw, m_ipsw, 1'b0, m_excode, 2'b00};
         CP0_EPC:      return m_epc;
         default:      return 0;
      endcase
   endfunction

   function automatic logic [4:0] m_ct();
      if (!cur.valid) return CAUSE_NONE;
      if (m_irq())    return EXC_INT;
      if (cur.exc)    return cur.code;
      if (cur.eret)   return CAUSE_ERET;
      return CAUSE_NONE;
   endfunction

   task automatic m_edge();
      logic irq = m_irq();
      logic ti_old = m_ti;
      logic wr = 0;
      logic [4:0] code;
      if (cur.valid && (irq || cur.exc)) begin
         code = irq ? EXC_INT : cur.code;
         m_excode = code;
         if (!m_status[1]) begin
            m_epc = cur.bd ? cur.pc - 4 : cur.pc;
            m_bd  = cur.bd;
         end
         m_status[1] = 1;
         if (code == EXC_ADEL || code == EXC_ADES) m_badv = cur.badv;
      end else if (cur.valid && cur.eret) begin
         m_status[1] = 0;
      end else if (cur.valid && cur.mtc0) begin
         wr = 1;
      end
      if (wr && cur.addr == CP0_COUNT) m_count = cur.wdata;
      else if (m_edges % 2 == 1) begin
         m_count = m_count + 1;
         if (m_count == m_compare) m_ti = 1;
      end
      if (wr && cur.addr == CP0_COMPARE) begin m_compare = cur.wdata; m_ti = 0; end
      if (wr && cur.addr == CP0_STATUS)  m_status = (m_status & ~32'hFF03) | (cur.wdata & 32'hFF03);
      if (wr && cur.addr == CP0_CAUSE)   m_ipsw = cur.wdata[9:8];
      if (wr && cur.addr == CP0_EPC)     m_epc = cur.wdata;
      m_iphw = {cur.hw[5] | ti_old, cur.hw[4:0]};
      m_edges++;
   endtask

   function automatic vin_t rnd();
      vin_t v = rd(alist[$urandom_range(0, 7)]);
      v.valid = ($urandom_range(0, 9) < 7);
      v.exc   = ($urandom_range(0, 7) == 0);
      v.code  = clist[$urandom_range(0, 5)];
      v.eret  = ($urandom_range(0, 5) == 0);
      v.mtc0  = ($urandom_range(0, 2) == 0);
      v.pc    = $urandom & 32'hFFFF_FFFC;
      v.bd    = $urandom_range(0, 1);
      v.badv  = $urandom;
      v.hw    = 6'($urandom & $urandom & $urandom);
      if (v.addr == CP0_COMPARE)    v.wdata = m_count + $urandom_range(0, 6);
      else if (v.addr == CP0_COUNT) v.wdata = m_compare - $urandom_range(0, 6);
      else                          v.wdata = $urandom;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  w;
      logic found;
      clist = '{EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV};
      cur = rd(CP0_STATUS);
      rst = 1;
      repeat (2) @(posedge clk);
      #4;
      chk_outs("reset", 0, CAUSE_NONE, 0, 0, 32'h0040_0000);
      nxt();
      rst = 0;

      // ---------- directed table ----------
      add(rd(CP0_STATUS), 0, 5'h1F, 0, 0, 32'h0040_0000);
      add(rd(CP0_CAUSE),  0, 5'h1F, 0, 0, 0);
      add(rd(CP0_EPC),    0, 5'h1F, 0, 0, 0);
      add(ex(EXC_OV, 32'h8000_0100, 1, 0, CP0_CAUSE), 1, 5'h0C, 0, 0, 0);
      add(rd(CP0_EPC),    0, 5'h1F, 32'h8000_00FC, 1, 32'h8000_00FC);
      add(rd(CP0_CAUSE),  0, 5'h1F, 32'h8000_00FC, 1, 32'h8000_0030);
      add(rd(CP0_STATUS), 0, 5'h1F, 32'h8000_00FC, 1, 32'h0040_0002);
      add(ex(EXC_SYS, 32'h8000_0200, 0, 0, CP0_CAUSE), 1, 5'h08, 32'h8000_00FC, 1, 32'h8000_0030);
      add(rd(CP0_CAUSE),  0, 5'h1F, 32'h8000_00FC, 1, 32'h8000_0020);
      add(er(CP0_EPC),    0, 5'h10, 32'h8000_00FC, 1, 32'h8000_00FC);
      add(rd(CP0_STATUS), 0, 5'h1F, 32'h8000_00FC, 0, 32'h0040_0000);
      begin
         vin_t v = ex(EXC_BP, 32'h8000_0300, 0, 0, CP0_CAUSE);
         v.eret = 1;
         add(v, 1, 5'h09, 32'h8000_00FC, 0, 32'h8000_0020);
      end
      add(rd(CP0_CAUSE),  0, 5'h1F, 32'h8000_0300, 1, 32'h0000_0024);
      add(er(CP0_STATUS), 0, 5'h10, 32'h8000_0300, 1, 32'h0040_0002);
      add(mt(CP0_EPC, 32'h1234_5678), 0, 5'h1F, 32'h8000_0300, 0, 32'h8000_0300);
      add(er(CP0_EPC),    0, 5'h10, 32'h1234_5678, 0, 32'h1234_5678);
      add(mt(CP0_STATUS, 32'hFFFF_FFFF), 0, 5'h1F, 32'h1234_5678, 0, 32'h0040_0000);
      add(rd(CP0_STATUS), 0, 5'h1F, 32'h1234_5678, 1, 32'h0040_FF03);
      add(mt(CP0_STATUS, 0), 0, 5'h1F, 32'h1234_5678, 1, 32'h0040_FF03);
      add(mt(CP0_CAUSE, 32'hFFFF_FFFF), 0, 5'h1F, 32'h1234_5678, 0, 32'h0000_0024);
      add(rd(CP0_CAUSE),  0, 5'h1F, 32'h1234_5678, 0, 32'h0000_0324);
      add(mt(CP0_CAUSE, 0), 0, 5'h1F, 32'h1234_5678, 0, 32'h0000_0324);
      add(mt(CP0_BADVADDR, 32'hFFFF_FFFF), 0, 5'h1F, 32'h1234_5678, 0, 0);
      add(rd(CP0_BADVADDR), 0, 5'h1F, 32'h1234_5678, 0, 0);
      add(mt(8'h78, 32'hFFFF), 0, 5'h1F, 32'h1234_5678, 0, 0);
      add(rd(8'h78),      0, 5'h1F, 32'h1234_5678, 0, 0);
      begin
         vin_t v = ex(EXC_ADEL, 32'h0040_0010, 0, 32'h3, CP0_EPC);
         v.mtc0 = 1; v.wdata = 32'hDEAD_BEEF;
         add(v, 1, 5'h04, 32'h1234_5678, 0, 32'h1234_5678);
      end
      add(rd(CP0_BADVADDR), 0, 5'h1F, 32'h0040_0010, 1, 32'h3);
      add(rd(CP0_EPC),    0, 5'h1F, 32'h0040_0010, 1, 32'h0040_0010);
      add(er(CP0_CAUSE),  0, 5'h10, 32'h0040_0010, 1, 32'h0000_0010);
      add(ex(EXC_ADES, 32'h0040_0020, 1, 32'hABCD_0000, CP0_BADVADDR), 1, 5'h05, 32'h0040_0010, 0, 32'h3);
      add(rd(CP0_BADVADDR), 0, 5'h1F, 32'h0040_001C, 1, 32'hABCD_0000);
      add(ex(EXC_OV, 32'h0040_0030, 0, 32'h55, CP0_BADVADDR), 1, 5'h0C, 32'h0040_001C, 1, 32'hABCD_0000);
      add(rd(CP0_BADVADDR), 0, 5'h1F, 32'h0040_001C, 1, 32'hABCD_0000);
      add(er(CP0_CAUSE),  0, 5'h10, 32'h0040_001C, 1, 32'h8000_0030);
      begin
         vin_t v = ex(EXC_RI, 32'h999, 0, 32'h7, CP0_EPC);
         v.valid = 0; v.eret = 1; v.mtc0 = 1; v.wdata = 32'h11;
         add(v, 0, 5'h1F, 32'h0040_001C, 0, 32'h0040_001C);
      end
      add(rd(CP0_EPC),    0, 5'h1F, 32'h0040_001C, 0, 32'h0040_001C);
      add(rd(CP0_BADVADDR), 0, 5'h1F, 32'h0040_001C, 0, 32'hABCD_0000);

      for (int i = 0; i < rows.size(); i++) begin
         cur = rows[i].v;
         #4;
         chk_outs($sformatf("row%0d", i), rows[i].isexl, rows[i].ct, rows[i].epc,
                  rows[i].sexl, rows[i].rdata);
         nxt();
      end

      // ---------- timer interrupt sequence ----------
      cur = mt(CP0_COMPARE, 5);          #4; nxt();
      cur = mt(CP0_COUNT, 0);            #4; nxt();
      cur = mt(CP0_STATUS, 32'h8001);    #4; nxt();
      w = 0; found = 0;
      while (w < 30 && !found) begin
         cur = rd(CP0_CAUSE);
         #4;
         if (cp0_rdata[30]) found = 1;
         else begin nxt(); w++; end
      end
      chk("tmr.ti_set", 32'(found), 1);
      chk("tmr.no_irq_when_idle", 32'(is_exl), 0);
      nxt();
      cur = rd(CP0_COUNT);
      cur.valid = 1; cur.pc = 32'h0040_0100;
      #4;
      chk("tmr.irq_is_exl", 32'(is_exl), 1);
      chk("tmr.irq_code", 32'(cause_type), 32'(EXC_INT));
      chk("tmr.count_at_ti", cp0_rdata, 5);
      nxt();
      cur = mt(CP0_COMPARE, 100);
      #4;
      chk("tmr.epc", cp0_epc, 32'h0040_0100);
      chk("tmr.exl_masks_irq", 32'(is_exl), 0);
      nxt();
      cur = rd(CP0_CAUSE);
      #4;
      chk("tmr.ti_clr_bd_code", cp0_rdata & 32'hC000_007C, 0);
      chk("tmr.ip7", 32'(cp0_rdata[15]), 1);

      // ---------- asynchronous reset mid-cycle ----------
      nxt();
      cur = rd(CP0_STATUS);
      #2; rst = 1; #1;
      chk_outs("arst", 0, 5'h1F, 0, 0, 32'h0040_0000);
      cur.addr = CP0_COUNT;
      #1;
      chk("arst.count", cp0_rdata, 0);
      nxt(); nxt();
      rst = 0;

      // ---------- randomized against reference model ----------
      m_reset();
      for (int n = 0; n < 800; n++) begin
         cur = rnd();
         #4;
         chk_outs($sformatf("rnd%0d", n), cur.valid && (m_irq() || cur.exc), m_ct(),
                  m_epc, m_status[1], m_read(cur.addr));
         m_edge();
         nxt();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
